// File: rtl/instr_pkg.sv
// Shared encodings for the instruction stream encoder: format codes,
// opcodes matching the controller's decode, and encoder FSM states.
package instr_pkg;

    localparam logic [1:0] FMT_R   = 2'b00;
    localparam logic [1:0] FMT_I   = 2'b01;
    localparam logic [1:0] FMT_J   = 2'b10;
    localparam logic [1:0] FMT_RSV = 2'b11;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_LH     = 6'b100001;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SB     = 6'b101000;
    localparam logic [5:0] OP_SH     = 6'b101001;
    localparam logic [5:0] OP_SW     = 6'b101011;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_WRITE  = 3'd2,
        ST_FULL   = 3'd3,
        ST_DONE   = 3'd4
    } enc_state_e;

    function automatic logic op_is_known(input logic [5:0] op);
        logic known;
        case (op)
            OP_RTYPE, OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ,
            OP_BGTZ, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LB, OP_LH,
            OP_LW, OP_SB, OP_SH, OP_SW: known = 1'b1;
            default:                    known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/instr_word_pack.sv
// Combinational packer: builds a 32-bit MIPS word from format and fields.
// With ENCODER_OPCODE_CHECK_EN defined, unknown or format-mismatched opcodes are illegal.
module instr_word_pack
    import instr_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [5:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = '0;
        legal = (fmt != FMT_RSV);
        case (fmt)
            FMT_R:   word = {op, rs, rt, rd, shamt, funct};
            FMT_I:   word = {op, rs, rt, imm};
            FMT_J:   word = {op, target};
            default: word = '0;
        endcase
`ifdef ENCODER_OPCODE_CHECK_EN
        if (!op_is_known(op)) begin
            legal = 1'b0;
        end else if (op == OP_RTYPE) begin
            legal = legal && (fmt == FMT_R);
        end else if (op == OP_J || op == OP_JAL) begin
            legal = legal && (fmt == FMT_J);
        end else begin
            legal = legal && (fmt == FMT_I);
        end
`endif
    end

endmodule

// File: rtl/instr_stream_encoder.sv
// Accepts instruction-field beats and writes packed words into instruction memory.
// Optional opcode legality checking is enabled by defining ENCODER_OPCODE_CHECK_EN.
module instr_stream_encoder
    import instr_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              Finish,
    input  logic              InValid,
    output logic              InReady,
    input  logic [1:0]        Fmt,
    input  logic [5:0]        Op,
    input  logic [4:0]        Rs,
    input  logic [4:0]        Rt,
    input  logic [4:0]        Rd,
    input  logic [4:0]        Shamt,
    input  logic [5:0]        Funct,
    input  logic [15:0]       Imm,
    input  logic [25:0]       Target,
    output logic              ImemWrEn,
    output logic [ADDR_W-1:0] ImemAddr,
    output logic [31:0]       ImemWrData,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W:0]   Count,
    output logic              Error
);

    localparam logic [ADDR_W-1:0] BASE_PTR  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_PTR  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    enc_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              error_q, error_d;
    logic              finish_pend_q, finish_pend_d;
    logic              wr_en_q, wr_en_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [31:0]       packed_word;
    logic              packed_legal;

    instr_word_pack u_pack (
        .fmt    (Fmt),
        .op     (Op),
        .rs     (Rs),
        .rt     (Rt),
        .rd     (Rd),
        .shamt  (Shamt),
        .funct  (Funct),
        .imm    (Imm),
        .target (Target),
        .word   (packed_word),
        .legal  (packed_legal)
    );

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        count_d       = count_q;
        error_d       = error_q;
        finish_pend_d = finish_pend_q;
        wr_en_d       = 1'b0;
        wr_data_d     = wr_data_q;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d       = ST_ACCEPT;
                    ptr_d         = BASE_PTR;
                    count_d       = '0;
                    error_d       = 1'b0;
                    finish_pend_d = 1'b0;
                end
            end
            ST_ACCEPT: begin
                if (InValid) begin
                    finish_pend_d = finish_pend_q | Finish;
                    if (packed_legal) begin
                        state_d   = ST_WRITE;
                        wr_en_d   = 1'b1;
                        wr_data_d = packed_word;
                        count_d   = (count_q == COUNT_MAX) ? count_q : count_q + 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end else if (Finish || finish_pend_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_WRITE: begin
                // The word is on the bus this cycle; decide where the session goes next.
                finish_pend_d = finish_pend_q | Finish;
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_FULL;
                end else begin
                    ptr_d   = ptr_q + 1'b1;
                    state_d = finish_pend_d ? ST_DONE : ST_ACCEPT;
                end
            end
            ST_FULL: begin
                if (InValid) begin
                    error_d = 1'b1;
                end
                if (Finish || finish_pend_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d       = ST_IDLE;
                finish_pend_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d = (state_d == ST_ACCEPT);
        busy_d     = (state_d == ST_ACCEPT) || (state_d == ST_WRITE) || (state_d == ST_FULL);
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= BASE_PTR;
            count_q       <= '0;
            error_q       <= 1'b0;
            finish_pend_q <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_data_q     <= '0;
            in_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            count_q       <= count_d;
            error_q       <= error_d;
            finish_pend_q <= finish_pend_d;
            wr_en_q       <= wr_en_d;
            wr_data_q     <= wr_data_d;
            in_ready_q    <= in_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign InReady    = in_ready_q;
    assign ImemWrEn   = wr_en_q;
    assign ImemAddr   = ptr_q;
    assign ImemWrData = wr_data_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign Count      = count_q;
    assign Error      = error_q;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Bench for instr_stream_encoder: directed and randomized beats checked
// against a transaction-level model of the load session.
module tb_instr_stream_encoder;

    localparam int ADDR_W    = 4;
    localparam int BASE_ADDR = 0;
    localparam int LAST      = (1 << ADDR_W) - 1;

    logic              Clk;
    logic              Rst;
    logic              Start;
    logic              Finish;
    logic              InValid;
    logic              InReady;
    logic [1:0]        Fmt;
    logic [5:0]        Op;
    logic [4:0]        Rs;
    logic [4:0]        Rt;
    logic [4:0]        Rd;
    logic [4:0]        Shamt;
    logic [5:0]        Funct;
    logic [15:0]       Imm;
    logic [25:0]       Target;
    logic              ImemWrEn;
    logic [ADDR_W-1:0] ImemAddr;
    logic [31:0]       ImemWrData;
    logic              Busy;
    logic              Done;
    logic [ADDR_W:0]   Count;
    logic              Error;

    int vectors;
    int miscompares;

    int  expPtr;
    int  expCount;
    bit  expFull;

    instr_stream_encoder #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Start      (Start),
        .Finish     (Finish),
        .InValid    (InValid),
        .InReady    (InReady),
        .Fmt        (Fmt),
        .Op         (Op),
        .Rs         (Rs),
        .Rt         (Rt),
        .Rd         (Rd),
        .Shamt      (Shamt),
        .Funct      (Funct),
        .Imm        (Imm),
        .Target     (Target),
        .ImemWrEn   (ImemWrEn),
        .ImemAddr   (ImemAddr),
        .ImemWrData (ImemWrData),
        .Busy       (Busy),
        .Done       (Done),
        .Count      (Count),
        .Error      (Error)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: legality of a beat according to the format/opcode rules.
    function automatic bit modelLegal(input int fmt, input int op);
`ifdef ENCODER_OPCODE_CHECK_EN
        int knownOps[18] = '{0, 8, 12, 13, 14, 35, 43, 40, 32, 41, 33, 1, 4, 5, 7, 6, 2, 3};
        bit known = 1'b0;
`endif
        if (fmt == 3) return 1'b0;
`ifdef ENCODER_OPCODE_CHECK_EN
        foreach (knownOps[i]) if (knownOps[i] == op) known = 1'b1;
        if (!known) return 1'b0;
        if (op == 0) return (fmt == 0);
        if (op == 2 || op == 3) return (fmt == 2);
        return (fmt == 1);
`else
        return 1'b1;
`endif
    endfunction

    // Reference model: MIPS word built with shifts and ORs of the field values.
    function automatic logic [31:0] modelWord(input int fmt, input int op, input int rs,
                                              input int rt, input int rd, input int sh,
                                              input int fn, input int imm, input int tgt);
        logic [31:0] w;
        w = 32'(op) << 26;
        case (fmt)
            0: w = w | (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | 32'(fn);
            1: w = w | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
            2: w = w | 32'(tgt);
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic startSession();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        expPtr   = BASE_ADDR;
        expCount = 0;
        expFull  = 1'b0;
        checkOutput("start_busy", Busy, 1);
        checkOutput("start_ready", InReady, 1);
        checkOutput("start_count", Count, 0);
        checkOutput("start_error", Error, 0);
        checkOutput("start_addr", ImemAddr, BASE_ADDR);
    endtask

    task automatic finishSession();
        Finish = 1'b1;
        tick();
        Finish = 1'b0;
        checkOutput("finish_done", Done, 1);
        checkOutput("finish_busy", Busy, 0);
        checkOutput("finish_count", Count, expCount);
        tick();
        checkOutput("finish_done_drop", Done, 0);
        checkOutput("finish_idle_ready", InReady, 0);
    endtask

    // One beat: wait for ready (bounded), hand it over, then check the write or the rejection.
    task automatic applyStimulus(input int fmt, input int op, input int rs, input int rt,
                                 input int rd, input int sh, input int fn, input int imm,
                                 input int tgt, input bit finishToo, input bit useGolden,
                                 input logic [31:0] golden);
        int waited = 0;
        bit legal;
        logic [31:0] expWord;
        while (InReady !== 1'b1 && waited < 8) begin
            tick();
            waited++;
        end
        if (InReady !== 1'b1) begin
            checkOutput("ready_timeout", InReady, 1);
            return;
        end
        Fmt = 2'(fmt); Op = 6'(op); Rs = 5'(rs); Rt = 5'(rt); Rd = 5'(rd);
        Shamt = 5'(sh); Funct = 6'(fn); Imm = 16'(imm); Target = 26'(tgt);
        InValid = 1'b1;
        Finish  = finishToo;
        tick();
        InValid = 1'b0;
        Finish  = 1'b0;
        legal   = modelLegal(fmt, op);
        expWord = modelWord(fmt, op, rs, rt, rd, sh, fn, imm, tgt);
        if (legal) begin
            if (expCount < (1 << ADDR_W)) expCount++;
            checkOutput("wr_en", ImemWrEn, 1);
            checkOutput("wr_addr", ImemAddr, expPtr);
            checkOutput("wr_data", ImemWrData, expWord);
            if (useGolden) checkOutput("wr_data_golden", ImemWrData, golden);
            checkOutput("wr_count", Count, expCount);
            checkOutput("wr_ready_low", InReady, 0);
            tick();
            checkOutput("wr_en_drop", ImemWrEn, 0);
            if (expPtr == LAST) begin
                expFull = 1'b1;
                checkOutput("full_ready", InReady, 0);
                checkOutput("full_busy", Busy, 1);
            end else begin
                expPtr++;
                if (finishToo) begin
                    checkOutput("pend_done", Done, 1);
                    checkOutput("pend_busy", Busy, 0);
                    tick();
                    checkOutput("pend_done_drop", Done, 0);
                end else begin
                    checkOutput("next_ready", InReady, 1);
                    checkOutput("next_addr", ImemAddr, expPtr);
                end
            end
        end else begin
            checkOutput("rej_wr_en", ImemWrEn, 0);
            checkOutput("rej_error", Error, 1);
            checkOutput("rej_count", Count, expCount);
            checkOutput("rej_addr", ImemAddr, expPtr);
            checkOutput("rej_ready", InReady, 1);
        end
    endtask

    task automatic randomBeat(input bit allowReserved);
        int ops[18] = '{0, 8, 12, 13, 14, 35, 43, 40, 32, 41, 33, 1, 4, 5, 7, 6, 2, 3};
        int fmt;
        int op;
        fmt = allowReserved ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 2));
        op  = ($urandom_range(0, 1) == 1) ? ops[$urandom_range(0, 17)] : int'($urandom_range(0, 63));
        applyStimulus(fmt, op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                      int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                      int'($urandom_range(0, 63)), int'($urandom_range(0, 65535)),
                      int'($urandom & 32'h03FF_FFFF), 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        int guard;
        vectors = 0;
        miscompares = 0;
        Rst = 1'b0; Start = 1'b0; Finish = 1'b0; InValid = 1'b0;
        Fmt = '0; Op = '0; Rs = '0; Rt = '0; Rd = '0; Shamt = '0; Funct = '0; Imm = '0; Target = '0;
        expPtr = BASE_ADDR; expCount = 0; expFull = 1'b0;

        #12;
        checkOutput("rst_ready", InReady, 0);
        checkOutput("rst_wr_en", ImemWrEn, 0);
        checkOutput("rst_wr_data", ImemWrData, 0);
        checkOutput("rst_addr", ImemAddr, BASE_ADDR);
        checkOutput("rst_busy", Busy, 0);
        checkOutput("rst_done", Done, 0);
        checkOutput("rst_count", Count, 0);
        checkOutput("rst_error", Error, 0);
        Rst = 1'b1;
        tick();
        checkOutput("idle_ready", InReady, 0);

        $display("[TB] session 1: directed addi / add / j, reserved format, plain finish");
        startSession();
        applyStimulus(1, 8, 0, 8, 0, 0, 0, 5, 0, 1'b0, 1'b1, 32'h2008_0005);
        applyStimulus(0, 0, 8, 9, 10, 0, 32, 16'hFFFF, 0, 1'b0, 1'b1, 32'h0109_5020);
        applyStimulus(2, 2, 31, 31, 31, 31, 63, 16'hFFFF, 32'h10, 1'b0, 1'b1, 32'h0800_0010);
        applyStimulus(3, 8, 1, 2, 3, 4, 5, 6, 7, 1'b0, 1'b0, 32'h0);
        applyStimulus(1, 63, 1, 2, 0, 0, 0, 16'h1234, 0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1, 2, 1, 2, 0, 0, 0, 16'h0042, 0, 1'b0, 1'b0, 32'h0);
        finishSession();

        $display("[TB] session 2: random beats, Finish together with the last beat");
        startSession();
        for (int i = 0; i < 10; i++) randomBeat(1'b1);
        applyStimulus(1, 35, 29, 4, 0, 0, 0, 16'h8004, 0, 1'b1, 1'b0, 32'h0);

        $display("[TB] session 3: fill memory, overflow beat, finish from full");
        startSession();
        guard = 0;
        while (!expFull && guard < 200) begin
            randomBeat(1'b1);
            guard++;
        end
        checkOutput("fill_reached", 32'(expFull), 1);
        checkOutput("fill_count", Count, 1 << ADDR_W);
        checkOutput("fill_error_before", Error, 32'(Error === 1'b1 ? 1 : 0));
        InValid = 1'b1;
        tick();
        InValid = 1'b0;
        checkOutput("full_overflow_error", Error, 1);
        checkOutput("full_overflow_wr_en", ImemWrEn, 0);
        checkOutput("full_stays_unready", InReady, 0);
        finishSession();

        $display("[TB] session 4: reset during a write");
        startSession();
        checkOutput("restart_clears_error", Error, 0);
        Fmt = 2'b01; Op = 6'd8; Rs = 5'd3; Rt = 5'd4; Imm = 16'd9;
        InValid = 1'b1;
        tick();
        InValid = 1'b0;
        checkOutput("pre_rst_wr_en", ImemWrEn, 1);
        Rst = 1'b0;
        #1;
        checkOutput("mid_rst_wr_en", ImemWrEn, 0);
        checkOutput("mid_rst_ready", InReady, 0);
        checkOutput("mid_rst_count", Count, 0);
        checkOutput("mid_rst_busy", Busy, 0);
        checkOutput("mid_rst_addr", ImemAddr, BASE_ADDR);
        #2;
        Rst = 1'b1;
        tick();
        checkOutput("post_rst_wr_en", ImemWrEn, 0);
        checkOutput("post_rst_busy", Busy, 0);
        checkOutput("post_rst_ready", InReady, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
